// File: rtl/wall_probe.sv
// wall_probe: reads the maze along a sprite's leading edge and decides if a move is legal.
// Optional horizontal tunnel wrap is enabled by defining WALL_PROBE_TUNNEL_WRAP_EN.
module wall_probe #(
    parameter int         SPRITE_SIZE  = 8,
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] WALL_COLOUR  = 3'b001,
    parameter int         READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] xin,
    input  logic [6:0] yin,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [7:0] mem_x,
    output logic [6:0] mem_y,
    output logic       mem_rd,
    input  logic [2:0] mem_data,
    output logic       busy,
    output logic       done,
    output logic       blocked,
    output logic [7:0] xnext,
    output logic [6:0] ynext
);

    localparam int            CW = $clog2(SPRITE_SIZE + 1);
    localparam logic [8:0]    XW = 9'(SCREEN_W);
    localparam logic [7:0]    YH = 8'(SCREEN_H);
    localparam logic [8:0]    XS = 9'(SPRITE_SIZE);
    localparam logic [7:0]    YS = 8'(SPRITE_SIZE);
    localparam logic [CW-1:0] CN = CW'(SPRITE_SIZE);
    localparam logic [2:0]    DL = 3'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]              r_x;
    logic [6:0]              r_y;
    logic [3:0]              r_dir;
    logic [CW-1:0]           r_cnt;
    logic [2:0]              r_dcnt;
    logic                    r_hit;
    logic [READ_LATENCY-1:0] r_vld;

    logic [7:0] r_mem_x;
    logic [6:0] r_mem_y;
    logic       r_mem_rd;
    logic       r_busy;
    logic       r_done;
    logic       r_blocked;
    logic [7:0] r_xnext;
    logic [6:0] r_ynext;

    logic [8:0] w_x9;
    logic [7:0] w_y8;
    logic       w_xspan;
    logic       w_yspan;
    logic       w_onehot;
    logic [3:0] w_dir;
    logic [7:0] w_px;
    logic [6:0] w_py;
    logic [7:0] w_cx;
    logic [6:0] w_cy;
    logic       w_vary_x;
    logic       w_oob;
    logic       w_sample;
    logic       w_hit;

    assign mem_x   = r_mem_x;
    assign mem_y   = r_mem_y;
    assign mem_rd  = r_mem_rd;
    assign busy    = r_busy;
    assign done    = r_done;
    assign blocked = r_blocked;
    assign xnext   = r_xnext;
    assign ynext   = r_ynext;

    // One extra bit so that edges past the screen are caught instead of wrapping.
    assign w_x9     = {1'b0, r_x};
    assign w_y8     = {1'b0, r_y};
    assign w_xspan  = (w_x9 + XS - 9'd1) >= XW;
    assign w_yspan  = (w_y8 + YS - 8'd1) >= YH;
    assign w_onehot = (r_dir != 4'd0) && ((r_dir & (r_dir - 4'd1)) == 4'd0);
    assign w_dir    = w_onehot ? r_dir : 4'd0;

    assign w_sample = r_vld[READ_LATENCY-1];
    assign w_hit    = r_hit | (w_sample && (mem_data == WALL_COLOUR));

    always_comb begin
        w_px     = r_x;
        w_py     = r_y;
        w_cx     = r_x;
        w_cy     = r_y;
        w_vary_x = 1'b0;
        w_oob    = 1'b1;
        unique case (1'b1)
            w_dir[3]: begin
                w_py     = r_y - 7'd1;
                w_cy     = r_y - 7'd1;
                w_vary_x = 1'b1;
                w_oob    = (r_y == 7'd0) || w_xspan;
            end
            w_dir[2]: begin
                w_py     = r_y + 7'(SPRITE_SIZE);
                w_cy     = r_y + 7'd1;
                w_vary_x = 1'b1;
                w_oob    = ((w_y8 + YS) >= YH) || w_xspan;
            end
            w_dir[1]: begin
                w_px  = r_x - 8'd1;
                w_cx  = r_x - 8'd1;
                w_oob = (r_x == 8'd0) || w_yspan;
`ifdef WALL_PROBE_TUNNEL_WRAP_EN
                if (r_x == 8'd0) begin
                    w_px  = 8'(SCREEN_W - 1);
                    w_cx  = 8'(SCREEN_W - SPRITE_SIZE);
                    w_oob = w_yspan;
                end
`endif
            end
            w_dir[0]: begin
                w_px  = r_x + 8'(SPRITE_SIZE);
                w_cx  = r_x + 8'd1;
                w_oob = ((w_x9 + XS) >= XW) || w_yspan;
`ifdef WALL_PROBE_TUNNEL_WRAP_EN
                if (w_x9 == (XW - XS)) begin
                    w_px  = 8'd0;
                    w_cx  = 8'd0;
                    w_oob = w_yspan;
                end
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (start) w_next = CALC;
            CALC:  w_next = (!w_onehot || w_oob) ? DONE : READ;
            READ:  if (r_cnt == CN) w_next = DRAIN;
            DRAIN: if (r_dcnt == DL) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x       <= 8'd0;
            r_y       <= 7'd0;
            r_dir     <= 4'd0;
            r_cnt     <= '0;
            r_dcnt    <= 3'd0;
            r_hit     <= 1'b0;
            r_vld     <= '0;
            r_mem_x   <= 8'd0;
            r_mem_y   <= 7'd0;
            r_mem_rd  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_blocked <= 1'b0;
            r_xnext   <= 8'd0;
            r_ynext   <= 7'd0;
        end else begin
            r_done   <= (w_next == DONE);
            r_busy   <= (w_next == CALC) || (w_next == READ) ||
                        (w_next == DRAIN);
            r_mem_rd <= (w_next == READ);
            r_vld    <= (r_vld << 1) | READ_LATENCY'(r_mem_rd);

            if (r_state == IDLE && start) begin
                r_x   <= xin;
                r_y   <= yin;
                r_dir <= {up, down, left, right};
                r_cnt <= '0;
            end

            if (r_state == CALC)  r_hit <= 1'b0;
            else if (w_sample)    r_hit <= w_hit;

            if (r_state == DRAIN) r_dcnt <= r_dcnt + 3'd1;
            else                  r_dcnt <= 3'd0;

            if (w_next == READ) begin
                r_mem_x <= w_px + (w_vary_x ? 8'(r_cnt) : 8'd0);
                r_mem_y <= w_py + (w_vary_x ? 7'd0 : 7'(r_cnt));
                r_cnt   <= r_cnt + 1'b1;
            end

            // Early-exit paths (bad direction, off-screen) never read memory.
            if (w_next == DONE) begin
                if (r_state == CALC) begin
                    r_blocked <= 1'b1;
                    r_xnext   <= r_x;
                    r_ynext   <= r_y;
                end else begin
                    r_blocked <= w_hit;
                    r_xnext   <= w_hit ? r_x : w_cx;
                    r_ynext   <= w_hit ? r_y : w_cy;
                end
            end
        end
    end

endmodule

// File: doc/wall_probe.md
Name: wall_probe

Overview:
Read-side companion to the sprite draw path. Before the controller commits a move, this block takes the sprite's current top-left (x,y) and the requested direction. It reads the frame/maze memory along the leading edge the sprite would enter. It then reports whether the move is legal and the resulting next position. It sits between the pac-man controller (S_DRAW_WAIT to S_ERASE decision) and the maze memory read port.

Parameters:
SPRITE_SIZE, 8, sprite edge length in pixels; number of edge pixels probed
SCREEN_W, 160, screen width in pixels; legal x is 0..SCREEN_W-1
SCREEN_H, 120, screen height in pixels; legal y is 0..SCREEN_H-1
WALL_COLOUR, 3'b001, pixel colour treated as wall
READ_LATENCY, 1, cycles from mem_rd to valid mem_data (1..4)

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
start  input  1  request probe; sampled only in IDLE
xin  input  8  current sprite x (top-left)
yin  input  7  current sprite y (top-left)
up  input  1  direction request
down  input  1  direction request
left  input  1  direction request
right  input  1  direction request
mem_x  output  8  read address x
mem_y  output  7  read address y
mem_rd  output  1  read strobe, one pixel per cycle
mem_data  input  3  pixel colour, valid READ_LATENCY cycles after mem_rd
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse; result valid
blocked  output  1  1 = move illegal; held until next done
xnext  output  8  resulting x; held until next done
ynext  output  7  resulting y; held until next done

Behaviour:
- Reset is asynchronous, active-low; clock is clk. Reset values: all outputs 0, state IDLE.
- All outputs are registered.
- xin, yin and the direction bits are captured on the cycle start is accepted; later changes are ignored.
- start is ignored while busy.
- States: IDLE, CALC, READ, DRAIN, DONE.
- IDLE to CALC on start.
- CALC computes the candidate position and the edge line:
  - right: x' = xin+1; probe x = xin+SPRITE_SIZE, y = yin+k
  - left: x' = xin-1; probe x = xin-1, y = yin+k
  - up: y' = yin-1; probe x = xin+k, y = yin-1
  - down: y' = yin+1; probe x = xin+k, y = yin+SIZE
  - k runs 0..SPRITE_SIZE-1.
- Direction not exactly one-hot (none, or two or more bits set): blocked = 1, xnext = xin, ynext = yin, CALC goes straight to DONE.
- Bounds: a probe line outside 0..SCREEN_W-1 or 0..SCREEN_H-1 sets blocked = 1 and keeps the position unchanged, CALC to DONE. This includes left at xin = 0, up at yin = 0, and the far edges. Compute with one extra bit so that wrap is detected and not aliased.
- READ: mem_rd = 1 for exactly SPRITE_SIZE consecutive cycles, k = 0..SIZE-1 in order.
- DRAIN: READ_LATENCY cycles, mem_rd = 0, then DONE.
- A hit accumulator ORs (mem_data == WALL_COLOUR) for each returned sample. It is cleared in CALC.
- There is no early exit; latency is fixed.
- DONE lasts one cycle with done = 1, then returns to IDLE.
- blocked = hit; xnext/ynext = candidate if not blocked, else xin/yin.
- busy goes 0 in the DONE cycle; a start in the following IDLE cycle is accepted.
- Latency, with start sampled at edge 0:
  - done at cycle SPRITE_SIZE+READ_LATENCY+2, i.e. 11 with defaults.
  - done at cycle 2 for the bounds and invalid-direction paths.
- Reset mid-operation: return to IDLE immediately, mem_rd = 0, no done pulse. The hit accumulator is cleared.

Optional Feature:
Macro WALL_PROBE_TUNNEL_WRAP_EN.
- Defined: horizontal tunnel wrap.
  - left at xin = 0 probes x = SCREEN_W-1 and gives candidate x' = SCREEN_W-SPRITE_SIZE.
  - right at xin = SCREEN_W-SPRITE_SIZE probes x = 0 and gives candidate x' = 0.
  - Both are otherwise read and checked normally.
  - Vertical bounds still block.
- Undefined: those cases are bounds-blocked per Behaviour.

Test Plan:
- Open corridor, all-zero memory: start, xin=40, yin=30, right -> mem_rd for 8 cycles at x=48, y=30..37; done at cycle 11; blocked=0; xnext=41, ynext=30.
- Wall on edge: memory (x=39, y=33) = 3'b001; left from (40,30) -> blocked=1; xnext=40, ynext=30.
- Bounds: up at yin=0 -> no mem_rd, done at cycle 2, blocked=1, ynext=0. Down at yin=112 probes y=120 -> blocked=1.
- Invalid direction: up=1, left=1 -> done at cycle 2, blocked=1, position unchanged. A start pulsed again while busy is ignored (exactly one done).
- Reset mid-READ: resetn low at cycle 5 -> mem_rd=0, busy=0, done never pulses. A new probe afterwards gives a correct result.
- WALL_PROBE_TUNNEL_WRAP_EN defined, left at xin=0, clear memory -> probes x=159, blocked=0, xnext=152. Undefined -> blocked=1, xnext=0.
